control_sequencer: RTL and testbench

Hardwired control unit that fetches each instruction into the IR, decodes its 5-bit opcode and steps through the per-instruction T-states. It drives the bus, memory and register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the select/encode stage. It is the immediate upstream source of every register enable in the datapath.

---
 rtl/cpu_pkg.sv | 65 ++++++
 rtl/control_decode.sv | 70 +++++++
 rtl/control_sequencer.sv | 116 +++++++++++
 tb/tb_control_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-function and T-state definitions for the hardwired control unit.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALTED
    } state_t;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in;
        logic y_in, z_in, zlow_out, c_out, con_in;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic [3:0] alu_op;
        logic run, illegal;
    } ctrl_t;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
            OP_ORI, OP_BR, OP_JR, OP_JAL, OP_NOP, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Final T-state of each instruction; undefined opcodes end in T3.
    function automatic state_t last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return ST_T5;
            OP_LD, OP_ST: return ST_T7;
            OP_BR:        return ST_T6;
            OP_JAL:       return ST_T4;
            default:      return ST_T3;
        endcase
    endfunction

    function automatic logic [3:0] alu_func(input logic [4:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of {T-state, latched opcode, con} into the control strobe vector.
module control_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != ST_RESET) && (state != ST_HALTED);
        case (state)
            ST_T0: {ctrl.pc_out, ctrl.mar_in, ctrl.inc_pc, ctrl.z_in} = 4'b1111;
            ST_T1: {ctrl.zlow_out, ctrl.pc_in, ctrl.read, ctrl.mdr_in} = 4'b1111;
            ST_T2: {ctrl.mdr_out, ctrl.ir_in} = 2'b11;
            ST_T3: case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
                    {ctrl.grb, ctrl.r_out, ctrl.y_in} = 3'b111;
                OP_LDI, OP_LD, OP_ST: {ctrl.grb, ctrl.ba_out, ctrl.y_in} = 3'b111;
                OP_BR:  {ctrl.gra, ctrl.r_out, ctrl.con_in} = 3'b111;
                OP_JR:  {ctrl.gra, ctrl.r_out, ctrl.pc_in} = 3'b111;
                OP_JAL: {ctrl.pc_out, ctrl.grb, ctrl.r_in} = 3'b111;
                default: ctrl.illegal = !is_legal(opcode);
            endcase
            ST_T4: case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    {ctrl.grc, ctrl.r_out, ctrl.z_in} = 3'b111;
                    ctrl.alu_op = alu_func(opcode);
                end
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    {ctrl.c_out, ctrl.z_in} = 2'b11;
                    ctrl.alu_op = alu_func(opcode);
                end
                OP_LDI, OP_LD, OP_ST: begin
                    {ctrl.c_out, ctrl.z_in} = 2'b11;
                    ctrl.alu_op = ALU_ADD;
                end
                OP_BR:  {ctrl.pc_out, ctrl.y_in} = 2'b11;
                OP_JAL: {ctrl.gra, ctrl.r_out, ctrl.pc_in} = 3'b111;
                default: ;
            endcase
            ST_T5: case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                    {ctrl.zlow_out, ctrl.gra, ctrl.r_in} = 3'b111;
                OP_LD, OP_ST: {ctrl.zlow_out, ctrl.mar_in} = 2'b11;
                OP_BR: begin
                    {ctrl.c_out, ctrl.z_in} = 2'b11;
                    ctrl.alu_op = ALU_ADD;
                end
                default: ;
            endcase
            ST_T6: case (opcode)
                OP_LD: {ctrl.read, ctrl.mdr_in} = 2'b11;
                OP_ST: {ctrl.gra, ctrl.r_out, ctrl.mdr_in} = 3'b111;
                // The only place an input reaches an output without a register.
                OP_BR: {ctrl.zlow_out, ctrl.pc_in} = {con, con};
                default: ;
            endcase
            ST_T7: case (opcode)
                OP_LD: {ctrl.mdr_out, ctrl.gra, ctrl.r_in} = 3'b111;
                OP_ST: ctrl.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: state register, opcode latch and memory wait logic.
// Define CONTROL_MEM_HANDSHAKE_EN to stretch memory steps until mem_done is sampled high.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        mem_done,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    state_t     state_reg, state_next;
    logic [4:0] opcode_reg;
    logic       mem_hold;
    logic       unused_inputs;
    ctrl_t      ctrl;

`ifdef CONTROL_MEM_HANDSHAKE_EN
    // T1 of fetch always reads; LD_T6 reads and ST_T7 writes.
    assign mem_hold = !mem_done &&
                      ((state_reg == ST_T1) ||
                       (state_reg == ST_T6 && opcode_reg == OP_LD) ||
                       (state_reg == ST_T7 && opcode_reg == OP_ST));
    assign unused_inputs = ^ir[26:0];
`else
    assign mem_hold      = 1'b0;
    assign unused_inputs = ^{ir[26:0], mem_done};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_RESET;
            opcode_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_T2)
                opcode_reg <= ir[31:27];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET:  state_next = ST_T0;
            ST_HALTED: state_next = ST_HALTED;
            ST_T0:     state_next = ST_T1;
            ST_T1:     if (!mem_hold) state_next = ST_T2;
            ST_T2:     state_next = ST_T3;
            default: begin
                if (!mem_hold) begin
                    if (state_reg == last_step(opcode_reg))
                        state_next = (opcode_reg == OP_HALT || stop) ? ST_HALTED : ST_T0;
                    else
                        state_next = state_t'(state_reg + 4'd1);
                end
            end
        endcase
    end

    control_decode u_decode (
        .state  (state_reg),
        .opcode (opcode_reg),
        .con    (con),
        .ctrl   (ctrl)
    );

    assign PCout   = ctrl.pc_out;
    assign PCin    = ctrl.pc_in;
    assign IncPC   = ctrl.inc_pc;
    assign MARin   = ctrl.mar_in;
    assign MDRin   = ctrl.mdr_in;
    assign MDRout  = ctrl.mdr_out;
    assign Read    = ctrl.read;
    assign Write   = ctrl.write;
    assign IRin    = ctrl.ir_in;
    assign Yin     = ctrl.y_in;
    assign Zin     = ctrl.z_in;
    assign Zlowout = ctrl.zlow_out;
    assign Cout    = ctrl.c_out;
    assign CONin   = ctrl.con_in;
    assign Gra     = ctrl.gra;
    assign Grb     = ctrl.grb;
    assign Grc     = ctrl.grc;
    assign Rin     = ctrl.r_in;
    assign Rout    = ctrl.r_out;
    assign BAout   = ctrl.ba_out;
    assign alu_op  = ctrl.alu_op;
    assign run     = ctrl.run;
    assign illegal = ctrl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction strobe sequences from a step-list model.
module tb_control_sequencer;

`ifdef CONTROL_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = '0;
    logic        con = 1'b0, mem_done = 1'b1, stop = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
    logic Yin, Zin, Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [3:0] alu_op;
    logic run, illegal;

    control_sequencer dut (
        .clock(clock), .reset(reset), .ir(ir), .con(con), .mem_done(mem_done), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef logic [25:0] vec_t;
    vec_t act;
    assign act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
                  Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, illegal};

    localparam vec_t M_PCOUT = 26'h1 << 25, M_PCIN  = 26'h1 << 24, M_INCPC = 26'h1 << 23;
    localparam vec_t M_MARIN = 26'h1 << 22, M_MDRIN = 26'h1 << 21, M_MDROUT = 26'h1 << 20;
    localparam vec_t M_READ  = 26'h1 << 19, M_WRITE = 26'h1 << 18, M_IRIN  = 26'h1 << 17;
    localparam vec_t M_YIN   = 26'h1 << 16, M_ZIN   = 26'h1 << 15, M_ZLOW  = 26'h1 << 14;
    localparam vec_t M_COUT  = 26'h1 << 13, M_CONIN = 26'h1 << 12, M_GRA   = 26'h1 << 11;
    localparam vec_t M_GRB   = 26'h1 << 10, M_GRC   = 26'h1 << 9,  M_RIN   = 26'h1 << 8;
    localparam vec_t M_ROUT  = 26'h1 << 7,  M_BAOUT = 26'h1 << 6,  M_RUN   = 26'h1 << 1;
    localparam vec_t M_ILL   = 26'h1;

    int checks = 0, passed = 0;

    task automatic check(input string name, input vec_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %07h expected %07h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // One entry per cycle of an instruction; mem marks steps that wait on mem_done.
    typedef struct { vec_t v; bit mem; } step_t;
    step_t steps[$];

    task automatic push(input vec_t v, input bit m);
        step_t s;
        s.v = v; s.mem = m;
        steps.push_back(s);
    endtask

    function automatic vec_t alu_bits(input logic [4:0] op);
        logic [3:0] a;
        case (op)
            5'b00100:           a = 4'd1;
            5'b00101, 5'b01101: a = 4'd2;
            5'b00110, 5'b01110: a = 4'd3;
            default:            a = 4'd0;
        endcase
        return vec_t'(a) << 2;
    endfunction

    task automatic build(input logic [4:0] op, input logic c);
        steps.delete();
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0);
        push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 1);
        push(M_MDROUT | M_IRIN, 0);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push(M_GRB | M_ROUT | M_YIN, 0);
                push(M_GRC | M_ROUT | M_ZIN | alu_bits(op), 0);
                push(M_ZLOW | M_GRA | M_RIN, 0);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push(M_GRB | M_ROUT | M_YIN, 0);
                push(M_COUT | M_ZIN | alu_bits(op), 0);
                push(M_ZLOW | M_GRA | M_RIN, 0);
            end
            5'b00001: begin
                push(M_GRB | M_BAOUT | M_YIN, 0);
                push(M_COUT | M_ZIN, 0);
                push(M_ZLOW | M_GRA | M_RIN, 0);
            end
            5'b00000, 5'b00010: begin
                push(M_GRB | M_BAOUT | M_YIN, 0);
                push(M_COUT | M_ZIN, 0);
                push(M_ZLOW | M_MARIN, 0);
                if (op == 5'b00000) begin
                    push(M_READ | M_MDRIN, 1);
                    push(M_MDROUT | M_GRA | M_RIN, 0);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN, 0);
                    push(M_WRITE, 1);
                end
            end
            5'b10010: begin
                push(M_GRA | M_ROUT | M_CONIN, 0);
                push(M_PCOUT | M_YIN, 0);
                push(M_COUT | M_ZIN, 0);
                push(c ? (M_ZLOW | M_PCIN) : vec_t'(0), 0);
            end
            5'b10011: push(M_GRA | M_ROUT | M_PCIN, 0);
            5'b10100: begin
                push(M_PCOUT | M_GRB | M_RIN, 0);
                push(M_GRA | M_ROUT | M_PCIN, 0);
            end
            5'b11010, 5'b11011: push('0, 0);
            default: push(M_ILL, 0);
        endcase
    endtask

    // Entered at a falling edge with the DUT in T0; leaves at the falling edge after the last step.
    task automatic run_instr(input logic [31:0] instr, input logic c, input bit stp,
                             input bit rand_md, input int ld_wait, input int abort_at,
                             output int cyc, output bit aborted);
        build(instr[31:27], c);
        ir = instr; con = c;
        cyc = 0; aborted = 0;
        for (int i = 0; i < steps.size(); i++) begin
            for (int k = 0; k < 20; k++) begin
                bit md;
                check($sformatf("op%05b_step%0d", instr[31:27], i), steps[i].v | M_RUN);
                cyc++;
                if (i == abort_at) begin
                    reset = 1'b1;
                    #1;
                    check("reset_mid", '0);
                    @(negedge clock);
                    reset = 1'b0;
                    @(negedge clock);
                    aborted = 1;
                    return;
                end
                if (i == 3 && k == 0) ir = $urandom;
                if (rand_md)                    md = ($urandom_range(0, 1) == 1);
                else if (i >= 3 && k < ld_wait - 1) md = 1'b0;
                else                            md = 1'b1;
                if (k >= 8) md = 1'b1;
                mem_done = md;
                stop = (i == steps.size() - 1) ? stp : ($urandom_range(0, 3) == 0);
                @(negedge clock);
                if (!(HS && steps[i].mem && !md)) break;
            end
        end
    endtask

    task automatic halted_then_reset(input int n);
        for (int j = 0; j < n; j++) begin
            check("halted", '0);
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        check("halt_reset", '0);
        @(negedge clock);
        reset = 1'b0; stop = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_instr(input logic [31:0] instr, input logic c, input bit stp,
                            input bit rand_md, input int exp_len, input int ld_wait,
                            input int abort_at, input int halt_cycles);
        int cyc;
        bit aborted;
        run_instr(instr, c, stp, rand_md, ld_wait, abort_at, cyc, aborted);
        $display("instr %08h con=%0b stop=%0b cycles=%0d aborted=%0b", instr, c, stp, cyc, aborted);
        if (exp_len >= 0) check_int($sformatf("len_%08h", instr), cyc, exp_len);
        if (!aborted && (instr[31:27] == 5'b11011 || stp)) halted_then_reset(halt_cycles);
    endtask

    typedef struct { logic [31:0] ir; logic con; int len; } rec_t;
    rec_t tbl[17];

    initial begin
        tbl[0]  = '{32'h18918000, 1'b0, 6};   // ADD R1,R2,R3
        tbl[1]  = '{32'h20918000, 1'b0, 6};   // SUB
        tbl[2]  = '{32'h28918000, 1'b0, 6};   // AND
        tbl[3]  = '{32'h30918000, 1'b0, 6};   // OR
        tbl[4]  = '{32'h60900007, 1'b0, 6};   // ADDI
        tbl[5]  = '{32'h68900007, 1'b0, 6};   // ANDI
        tbl[6]  = '{32'h70900007, 1'b0, 6};   // ORI
        tbl[7]  = '{32'h08800011, 1'b0, 6};   // LDI
        tbl[8]  = '{32'h02000065, 1'b0, 8};   // LD R4,0x65(R0)
        tbl[9]  = '{32'h12000065, 1'b0, 8};   // ST
        tbl[10] = '{32'h90800004, 1'b0, 7};   // BR, not taken
        tbl[11] = '{32'h90800004, 1'b1, 7};   // BR, taken
        tbl[12] = '{32'h98800000, 1'b0, 4};   // JR
        tbl[13] = '{32'hA0800000, 1'b0, 5};   // JAL
        tbl[14] = '{32'hD0000000, 1'b0, 4};   // NOP
        tbl[15] = '{32'hF8000000, 1'b0, 4};   // undefined opcode 11111
        tbl[16] = '{32'hD8000000, 1'b0, 4};   // HALT

        repeat (2) @(negedge clock);
        check("reset", '0);
        reset = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 17; t++)
            do_instr(tbl[t].ir, tbl[t].con, 1'b0, 1'b0, tbl[t].len, 0, -1, 20);

        do_instr(32'h02000065, 1'b0, 1'b0, 1'b0, HS ? 10 : 8, 3, -1, 0);
        do_instr(32'h12000065, 1'b0, 1'b0, 1'b0, -1, 0, 6, 0);
        do_instr(32'h18918000, 1'b0, 1'b0, 1'b0, 6, 0, -1, 0);
        do_instr(32'hD8000000, 1'b0, 1'b1, 1'b0, 4, 0, -1, 3);
        do_instr(32'h18918000, 1'b0, 1'b1, 1'b0, 6, 0, -1, 3);

        for (int r = 0; r < 60; r++) begin
            logic [31:0] instr;
            instr = $urandom;
            do_instr(instr, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                     1'b1, -1, 0, -1, 3);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, checks);
        $fatal(1);
    end

endmodule
